// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the baud-derived timing
// constants used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // Clocks per bit period.
  function automatic int unsigned SymbolEdgeTime(int unsigned clock_freq,
                                                 int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clocks from the start edge to the centre of the start bit.
  function automatic int unsigned SampleTime(int unsigned clock_freq,
                                             int unsigned baud_rate);
    return SymbolEdgeTime(clock_freq, baud_rate) / 2;
  endfunction

  function automatic int unsigned CW(int unsigned clock_freq,
                                     int unsigned baud_rate);
    return $clog2(SymbolEdgeTime(clock_freq, baud_rate));
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Received-byte stream between the UART receiver and its consumer.
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  modport master (output DataOut, output DataOutValid, input DataOutReady);
  modport slave  (input DataOut, input DataOutValid, output DataOutReady);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: centre-samples the synchronized line, assembles bytes
// LSB first and hands them out on a valid/ready stream with error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreq = 100_000_000,
  parameter int unsigned BaudRate  = 115200
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              SIn,
  uart_receiver_if.master   rx,
  output logic              FramingError,
  output logic              Overrun
);

  localparam int unsigned SymT = SymbolEdgeTime(ClockFreq, BaudRate);
  localparam int unsigned SmpT = SampleTime(ClockFreq, BaudRate);
  localparam int unsigned CntW = CW(ClockFreq, BaudRate);
  localparam logic [CntW-1:0] SymLast = CntW'(SymT - 1);
  localparam logic [CntW-1:0] SmpLast = CntW'(SmpT - 1);

  logic s_in;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d_i     (SIn),
    .q_o     (s_in)
  );

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            vld_q, vld_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            deliver, stop_bad;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!s_in) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (cnt_q == SmpLast) state_d = s_in ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == SymLast) begin
          shift_d = {s_in, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = '0;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == SymLast) begin
          if (s_in) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off until the line recovers so a break is not read as 0x00s.
        cnt_d = '0;
        if (s_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    fe_d   = stop_bad;
    ov_d   = 1'b0;

    if (vld_q && rx.DataOutReady) vld_d = 1'b0;

    // A byte arriving on the same cycle the old one leaves still loads.
    if (deliver) begin
      if (!vld_q || rx.DataOutReady) begin
        data_d = shift_q;
        vld_d  = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign rx.DataOut      = data_q;
  assign rx.DataOutValid = vld_q;
  assign FramingError    = fe_q;
  assign Overrun         = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit.
module tb_uart_receiver;

  logic Clock = 1'b0;
  logic Reset_n;
  logic SIn;
  logic FramingError, Overrun;

  uart_receiver_if rx_if ();

  uart_receiver #(.ClockFreq(1_000_000), .BaudRate(100_000)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .SIn          (SIn),
    .rx           (rx_if),
    .FramingError (FramingError),
    .Overrun      (Overrun)
  );

  always #5 Clock = ~Clock;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int t_fall, t_a;
  int rise_cnt = 0, rise_cyc = -1, vld_hi = 0;
  int fe_cnt = 0, fe_cyc = -1, ov_cnt = 0, ov_cyc = -1;
  logic vld_prev = 1'b0;
  logic [7:0] beats[$];
  int r0, f0, o0, h0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (rx_if.DataOutValid && !vld_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (rx_if.DataOutValid) vld_hi <= vld_hi + 1;
    if (rx_if.DataOutValid && rx_if.DataOutReady) beats.push_back(rx_if.DataOut);
    if (FramingError) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (Overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    vld_prev <= rx_if.DataOutValid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SIn = b;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic consume();
    rx_if.DataOutReady = 1'b1;
    tick(1);
    rx_if.DataOutReady = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    SIn = 1'b1;
    rx_if.DataOutReady = 1'b0;
    tick(3);
    check("rst_data", rx_if.DataOut, 8'h00);
    check("rst_valid", rx_if.DataOutValid, 1'b0);
    check("rst_fe", FramingError, 1'b0);
    check("rst_ov", Overrun, 1'b0);
    Reset_n = 1'b1;
    tick(5);

    // Single frame, consumer not ready.
    send_frame(8'h21, 1'b1);
    check("f21_latency", rise_cyc, t_fall + 98);
    check("f21_valid", rx_if.DataOutValid, 1'b1);
    check("f21_data", rx_if.DataOut, 8'h21);
    tick(10);
    check("f21_hold_valid", rx_if.DataOutValid, 1'b1);
    check("f21_hold_data", rx_if.DataOut, 8'h21);
    consume();
    check("f21_drained", rx_if.DataOutValid, 1'b0);
    check("f21_beats", rise_cnt, 1);

    // Short glitch on the line, then a real frame.
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    SIn = 1'b0;
    tick(3);
    SIn = 1'b1;
    tick(20);
    check("glitch_valid", rx_if.DataOutValid, 1'b0);
    check("glitch_rises", rise_cnt, r0);
    check("glitch_fe", fe_cnt, f0);
    check("glitch_ov", ov_cnt, o0);
    send_frame(8'hA5, 1'b1);
    check("fA5_valid", rx_if.DataOutValid, 1'b1);
    check("fA5_data", rx_if.DataOut, 8'hA5);
    check("fA5_latency", rise_cyc, t_fall + 98);
    consume();

    // Bad stop bit followed by a held-low (break) line.
    tick(5);
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    tick(30);
    check("brk_fe_count", fe_cnt, f0 + 1);
    check("brk_fe_time", fe_cyc, t_fall + 98);
    check("brk_valid", rx_if.DataOutValid, 1'b0);
    check("brk_rises", rise_cnt, r0);
    SIn = 1'b1;
    tick(20);
    check("brk_fe_after", fe_cnt, f0 + 1);
    send_frame(8'h3C, 1'b1);
    check("f3C_valid", rx_if.DataOutValid, 1'b1);
    check("f3C_data", rx_if.DataOut, 8'h3C);
    consume();

    // Back-to-back frames into a full holding register.
    tick(5);
    o0 = ov_cnt; f0 = fe_cnt;
    send_frame(8'h41, 1'b1);
    t_a = t_fall;
    send_frame(8'h42, 1'b1);
    check("ovr_spacing", t_fall, t_a + 100);
    check("ovr_data", rx_if.DataOut, 8'h41);
    check("ovr_valid", rx_if.DataOutValid, 1'b1);
    check("ovr_count", ov_cnt, o0 + 1);
    check("ovr_time", ov_cyc, t_fall + 98);
    check("ovr_fe", fe_cnt, f0);
    consume();
    check("ovr_drained", rx_if.DataOutValid, 1'b0);

    // Always-ready consumer, extreme byte values back to back.
    tick(5);
    beats.delete();
    h0 = vld_hi; o0 = ov_cnt; f0 = fe_cnt;
    rx_if.DataOutReady = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(5);
    check("rdy_beats", beats.size(), 2);
    check("rdy_beat0", beats[0], 8'h00);
    check("rdy_beat1", beats[1], 8'hFF);
    check("rdy_valid_cycles", vld_hi, h0 + 2);
    check("rdy_ov", ov_cnt, o0);
    check("rdy_fe", fe_cnt, f0);
    rx_if.DataOutReady = 1'b0;

    // Reset in the middle of the 4th data bit of 0x99.
    tick(5);
    SIn = 1'b0;
    tick(10);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    SIn = 1'b1;
    tick(4);
    Reset_n = 1'b0;
    #2;
    check("mid_rst_data", rx_if.DataOut, 8'h00);
    check("mid_rst_valid", rx_if.DataOutValid, 1'b0);
    check("mid_rst_fe", FramingError, 1'b0);
    check("mid_rst_ov", Overrun, 1'b0);
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    tick(3);
    Reset_n = 1'b1;
    tick(150);
    check("post_rst_valid", rx_if.DataOutValid, 1'b0);
    check("post_rst_rises", rise_cnt, r0);
    check("post_rst_fe", fe_cnt, f0);
    check("post_rst_ov", ov_cnt, o0);
    send_frame(8'h7E, 1'b1);
    check("f7E_valid", rx_if.DataOutValid, 1'b1);
    check("f7E_data", rx_if.DataOut, 8'h7E);
    check("f7E_latency", rise_cyc, t_fall + 98);
    consume();
    check("f7E_drained", rx_if.DataOutValid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
